a2d_resp: RTL and testbench
===========================

Name: a2d_resp

Overview:
- Synthesizable SPI responder that emulates the 8-channel, 12-bit ADC128S-style A2D on the DE0 board.
- It answers the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO interface driven by the eBike A2D initiator.
- Used as the far end of that link in full-chip simulation, and on a loopback FPGA build where analog inputs are replaced by register values.
- Protocol matches the real part: a frame addresses a channel, and the following frame returns that channel's conversion.

Parameters:
- RESET_CHNL, 3'd0, channel whose data is returned in the first frame after reset.
- MIN_SCLK_DIV, 8, minimum supported SCLK period in clk cycles; documentation and assertion only.

Ports:
- clk  input  1  50MHz system clock.
- rst_n  input  1  reset, synchronous, active-low.
- SS_n  input  1  slave select from initiator, active low, asynchronous to clk.
- SCLK  input  1  SPI clock from initiator, mode 0, idles low.
- MOSI  input  1  serial command from initiator.
- MISO  output  1  serial data to initiator.
- chnl_data  input  96  eight packed 12-bit values; channel n occupies bits [12n+11:12n].
- chnl  output  3  channel addressed by last valid frame.
- frm_done  output  1  one-clk pulse when a valid 16-bit frame completes.
- frm_err  output  1  one-clk pulse when SS_n deasserts after a bit count other than 16.

Behaviour:
- Reset values: MISO=0, chnl=RESET_CHNL, frm_done=0, frm_err=0, FSM=IDLE, bit count=0.
- Input synchronisation: SS_n, SCLK and MOSI each pass through 2 flops, plus a 3rd flop for edge detection.
  - Detected edges lag the pins by 3 clk.
  - Synchroniser flops reset to SS_n=1, SCLK=0, MOSI=0.
- FSM has two states, IDLE and SHIFT.
- IDLE → SHIFT on a synchronised SS_n falling edge. In the same cycle:
  - load tx_shft[15:0] = {4'h0, chnl_data[chnl]};
  - clear rx_shft;
  - clear bit count.
- MISO = tx_shft[15] at all times. The MSB is therefore valid before the first SCLK rise, as mode 0 requires.
- SHIFT, SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}. Bit count increments, saturating at 31.
- SHIFT, SCLK fall: tx_shft <= {tx_shft[14:0], 1'b0}. A fall before the first rise is ignored, so MSB is not lost.
- SHIFT → IDLE on a synchronised SS_n rising edge:
  - count==16: chnl <= rx_shft[13:11], frm_done=1 for one clk.
  - any other count: chnl unchanged, frm_err=1 for one clk.
  - In both cases tx_shft clears to 0, so MISO=0 while idle.
- SCLK/MOSI activity while in IDLE is ignored.
- Simultaneous SS_n fall and SCLK edge in one clk: the SS_n fall wins and the SCLK edge is dropped. This is legal only if the initiator violates setup; covered by an assertion.
- chnl_data is sampled only at the SS_n fall. Later changes do not affect the frame in flight.
- Reset asserted mid-frame: return to IDLE with reset values. A subsequent SS_n rise must not produce frm_done or frm_err.
- Constraint: SCLK high and low phases must each be ≥ 4 clk (MIN_SCLK_DIV/2). Assertion fires otherwise.
- Timing: MISO changes 4 clk after the SCLK fall at the pin. This is well inside a clk/32 SCLK period.

Decomposition:
- Shared package a2d_pkg:
  - typedef chnl_t (logic [2:0]);
  - A2D_DATA_W=12, A2D_FRM_BITS=16, A2D_NUM_CH=8;
  - localparam CH_BATT, CH_BRAKE, CH_TORQUE, CH_CURR channel indices, shared with the initiator.
- One sub-module: spi_in_sync (3-flop synchroniser plus rise/fall detect), instantiated for SS_n and SCLK. MOSI uses only its 2-flop path.

Test Plan:
- After reset, frame with MOSI=16'h0000 and chnl_data[11:0]=12'hABC → MISO returns 16'h0ABC; frm_done pulses; chnl=0.
- Frame selecting ch 3 (MOSI=16'h1800), then frame with chnl_data ch3=12'h5A5 → second frame's MISO=16'h05A5; chnl=3 after the first frame.
- Back-to-back frames ch1→ch4→ch1 at SCLK=clk/32, with distinct values 12'h111/12'h444 → each returned word is the value of the channel addressed in the previous frame.
- SS_n raised after 9 SCLK rises → frm_err pulses once; chnl unchanged; next full frame still correct.
- chnl_data changed mid-frame from 12'h123 to 12'hFFF → shifted word remains 16'h0123.
- rst_n low for 1 clk mid-frame, then SS_n rise → no frm_done/frm_err; MISO=0; chnl=RESET_CHNL.

Source files
------------

// File: rtl/a2d_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_pkg
//  Purpose  : Shared types and constants for the ADC128S-style A2D SPI link.
//             Channel indices are shared with the eBike A2D initiator.
//  Revision : 1.0  initial release
// ============================================================================
package a2d_pkg;

    typedef logic [2:0] chnl_t;

    localparam int A2D_DATA_W   = 12;
    localparam int A2D_FRM_BITS = 16;
    localparam int A2D_NUM_CH   = 8;

    localparam chnl_t CH_BATT   = 3'd0;
    localparam chnl_t CH_BRAKE  = 3'd1;
    localparam chnl_t CH_TORQUE = 3'd2;
    localparam chnl_t CH_CURR   = 3'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } a2d_state_t;

    // Pick one 12-bit conversion out of the packed 8-channel bus.
    function automatic logic [A2D_DATA_W-1:0] chnl_word(
        input logic [A2D_NUM_CH*A2D_DATA_W-1:0] data,
        input chnl_t                             ch
    );
        return data[ch*A2D_DATA_W +: A2D_DATA_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_in_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_in_sync
//  Purpose  : Two-flop synchroniser for an asynchronous SPI pin plus a third
//             flop for edge detection. Edges appear 3 clk after the pin.
//  Ports    : clk, rst_n (sync, active-low), din (async pin)
//             sync (synchronised level), rise / fall (one-clk edge pulses)
//  Revision : 1.0  initial release
// ============================================================================
module spi_in_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            dly_q  <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise =  sync_q & ~dly_q;
    assign fall = ~sync_q &  dly_q;

endmodule
`default_nettype wire

// File: rtl/a2d_resp.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_resp
//  Purpose  : SPI responder emulating an 8-channel 12-bit ADC128S-style A2D.
//             A frame addresses a channel; the next frame returns that
//             channel's value as {4'h0, data[11:0]}, MSB first, SPI mode 0.
//  Ports    : clk, rst_n      - system clock, synchronous active-low reset
//             SS_n/SCLK/MOSI  - asynchronous SPI inputs from the initiator
//             MISO            - serial data back to the initiator
//             chnl_data[95:0] - channel n at bits [12n+11:12n]
//             chnl            - channel addressed by the last valid frame
//             frm_done        - one-clk pulse, valid 16-bit frame finished
//             frm_err         - one-clk pulse, frame ended with bad bit count
//  Revision : 1.0  initial release
// ============================================================================
module a2d_resp
    import a2d_pkg::*;
#(
    parameter chnl_t RESET_CHNL   = 3'd0,
    parameter int    MIN_SCLK_DIV = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             SS_n,
    input  logic                             SCLK,
    input  logic                             MOSI,
    output logic                             MISO,
    input  logic [A2D_NUM_CH*A2D_DATA_W-1:0] chnl_data,
    output chnl_t                            chnl,
    output logic                             frm_done,
    output logic                             frm_err
);

    localparam logic [4:0] BIT_CNT_MAX = 5'd31;
    localparam logic [4:0] FRM_BITS    = 5'(A2D_FRM_BITS);

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync, sclk_rise, sclk_fall;

    spi_in_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SS_n),
        .sync  (ss_sync),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_in_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SCLK),
        .sync  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // MOSI only needs the two-flop path; its second stage lines up in time
    // with the synchronised SCLK rise.
    logic mosi_meta_q, mosi_sync_q;

    // After reset the SS_n synchroniser holds its reset value (high) for two
    // cycles. If the pin is really low (reset hit mid-frame) that would look
    // like a falling edge, so falls are only accepted once SS_n has been seen
    // high with pin-derived data in the synchroniser.
    logic [1:0] post_rst_q;
    logic       armed_q, armed_d;

    a2d_state_t      state_q, state_d;
    logic [15:0]     tx_shft_q, tx_shft_d;
    logic [15:0]     rx_shft_q, rx_shft_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    chnl_t           chnl_q, chnl_d;
    logic            frm_done_q, frm_done_d;
    logic            frm_err_q, frm_err_d;

    always_comb begin
        state_d    = state_q;
        tx_shft_d  = tx_shft_q;
        rx_shft_d  = rx_shft_q;
        bit_cnt_d  = bit_cnt_q;
        chnl_d     = chnl_q;
        frm_done_d = 1'b0;
        frm_err_d  = 1'b0;
        armed_d    = armed_q | ((post_rst_q == 2'b11) & ss_sync);

        case (state_q)
            ST_IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d   = ST_SHIFT;
                    tx_shft_d = {4'h0, chnl_word(chnl_data, chnl_q)};
                    rx_shft_d = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d   = ST_IDLE;
                    tx_shft_d = '0;
                    if (bit_cnt_q == FRM_BITS) begin
                        chnl_d     = rx_shft_q[13:11];
                        frm_done_d = 1'b1;
                    end else begin
                        frm_err_d  = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_shft_d = (rx_shft_q << 1) | {15'd0, mosi_sync_q};
                        if (bit_cnt_q != BIT_CNT_MAX) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                    // A fall before the first rise would throw away the MSB.
                    if (sclk_fall && (bit_cnt_q != 5'd0)) begin
                        tx_shft_d = tx_shft_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            post_rst_q  <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            tx_shft_q   <= '0;
            rx_shft_q   <= '0;
            bit_cnt_q   <= '0;
            chnl_q      <= RESET_CHNL;
            frm_done_q  <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
            post_rst_q  <= {post_rst_q[0], 1'b1};
            armed_q     <= armed_d;
            state_q     <= state_d;
            tx_shft_q   <= tx_shft_d;
            rx_shft_q   <= rx_shft_d;
            bit_cnt_q   <= bit_cnt_d;
            chnl_q      <= chnl_d;
            frm_done_q  <= frm_done_d;
            frm_err_q   <= frm_err_d;
        end
    end

    assign MISO     = tx_shft_q[15];
    assign chnl     = chnl_q;
    assign frm_done = frm_done_q;
    assign frm_err  = frm_err_q;

`ifndef SYNTHESIS
    // Each synchronised SCLK phase must last at least half the minimum period.
    localparam logic [7:0] MIN_PHASE = 8'(MIN_SCLK_DIV / 2);
    logic [7:0] phase_cnt_q;
    logic       sclk_lvl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_cnt_q <= '1;
            sclk_lvl_q  <= 1'b0;
        end else begin
            sclk_lvl_q <= sclk_sync;
            if (sclk_sync != sclk_lvl_q) begin
                phase_cnt_q <= 8'd1;
            end else if (phase_cnt_q != '1) begin
                phase_cnt_q <= phase_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_SHIFT) && (sclk_sync != sclk_lvl_q)) begin
            assert (phase_cnt_q >= MIN_PHASE);
        end
        // An SCLK edge coincident with the SS_n fall is dropped.
        if (rst_n && (state_q == ST_IDLE) && armed_q && ss_fall) begin
            assert (!(sclk_rise || sclk_fall));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_a2d_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_a2d_resp
//  Purpose  : Self-checking bench for a2d_resp. A behavioural model tracks
//             the addressed channel and the channel values; every returned
//             word and every frame pulse count is checked against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_a2d_resp;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [95:0] chnl_data;
    logic [2:0]  chnl;
    logic        frm_done;
    logic        frm_err;

    a2d_resp u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .chnl_data (chnl_data),
        .chnl      (chnl),
        .frm_done  (frm_done),
        .frm_err   (frm_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Model state: channel values and the channel the next frame returns.
    logic [11:0] ch_val [8];
    logic [2:0]  model_chnl;

    always_comb begin
        chnl_data = '0;
        for (int n = 0; n < 8; n++) chnl_data[n*12 +: 12] = ch_val[n];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (frm_done === 1'b1) done_cnt++;
        if (frm_err  === 1'b1) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI mode-0 master, SCLK = clk/32. Optionally rewrites one channel value
    // after bit chg_bit to check that data is captured only at SS_n fall.
    task automatic spi_frame(input logic [15:0] tx, input int nbits,
                             input int chg_bit, input logic [2:0] chg_ch,
                             input logic [11:0] chg_val,
                             output logic [15:0] rx);
        rx   = '0;
        SS_n = 1'b0;
        wait_clk(16);
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[15-i];
            wait_clk(8);
            rx[15-i] = MISO;
            SCLK = 1'b1;
            wait_clk(16);
            SCLK = 1'b0;
            if (i == chg_bit) ch_val[chg_ch] = chg_val;
            wait_clk(8);
        end
        wait_clk(8);
        SS_n = 1'b1;
        wait_clk(8);
    endtask

    // Full frame checked against the model; the model then moves to the
    // channel addressed by this frame.
    task automatic model_frame(input string name, input logic [2:0] addr);
        logic [15:0] rx, exp;
        int d0, e0;
        d0  = done_cnt;
        e0  = err_cnt;
        exp = {4'h0, ch_val[model_chnl]};
        spi_frame({2'b00, addr, 11'd0}, 16, -1, 3'd0, 12'd0, rx);
        model_chnl = addr;
        n_checks++;
        if (rx !== exp) begin
            n_fail++;
            $display("FAIL %s miso: got %h expected %h", name, rx, exp);
        end
        n_checks++;
        if ((done_cnt - d0) != 1 || (err_cnt - e0) != 0) begin
            n_fail++;
            $display("FAIL %s pulses: done %0d err %0d expected 1/0", name,
                     done_cnt - d0, err_cnt - e0);
        end
        n_checks++;
        if (chnl !== model_chnl) begin
            n_fail++;
            $display("FAIL %s chnl: got %0d expected %0d", name, chnl, model_chnl);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        model_chnl = 3'd0;
        wait_clk(6);
        n_checks++;
        if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        n_checks++;
        if (chnl !== 3'd0) begin n_fail++; $display("FAIL reset_chnl: got %0d expected 0", chnl); end
        n_checks++;
        if (frm_done !== 1'b0 || frm_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: done %b err %b expected 0/0", frm_done, frm_err);
        end
    endtask

    task automatic test_first_frame;
        ch_val[0] = 12'hABC;
        model_frame("first_frame", 3'd0);
    endtask

    task automatic test_select_ch3;
        model_frame("select_ch3", 3'd3);
        ch_val[3] = 12'h5A5;
        model_frame("read_ch3", 3'($urandom_range(0, 7)));
    endtask

    task automatic test_back_to_back;
        ch_val[1] = 12'h111;
        ch_val[4] = 12'h444;
        model_frame("b2b_a", 3'd1);
        model_frame("b2b_b", 3'd4);
        model_frame("b2b_c", 3'd1);
        model_frame("b2b_d", 3'd2);
    endtask

    task automatic test_short_frame;
        logic [15:0] rx;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        spi_frame({2'b00, 3'd6, 11'd0}, 9, -1, 3'd0, 12'd0, rx);
        n_checks++;
        if ((err_cnt - e0) != 1 || (done_cnt - d0) != 0) begin
            n_fail++;
            $display("FAIL short_frame pulses: err %0d done %0d expected 1/0",
                     err_cnt - e0, done_cnt - d0);
        end
        n_checks++;
        if (chnl !== model_chnl) begin
            n_fail++;
            $display("FAIL short_frame chnl: got %0d expected %0d", chnl, model_chnl);
        end
        model_frame("after_short", 3'd5);
    endtask

    task automatic test_midframe_change;
        logic [15:0] rx;
        logic [2:0]  ch;
        ch = model_chnl;
        ch_val[ch] = 12'h123;
        spi_frame({2'b00, 3'd7, 11'd0}, 16, 4, ch, 12'hFFF, rx);
        model_chnl = 3'd7;
        n_checks++;
        if (rx !== 16'h0123) begin
            n_fail++;
            $display("FAIL midframe_change miso: got %h expected 0123", rx);
        end
        n_checks++;
        if (chnl !== 3'd7) begin
            n_fail++;
            $display("FAIL midframe_change chnl: got %0d expected 7", chnl);
        end
    endtask

    task automatic test_reset_midframe;
        int d0, e0;
        SS_n = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 6; i++) begin
            MOSI = 1'b1;
            wait_clk(8);
            SCLK = 1'b1;
            wait_clk(16);
            SCLK = 1'b0;
            wait_clk(8);
        end
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        model_chnl = 3'd0;
        d0 = done_cnt;
        e0 = err_cnt;
        wait_clk(16);
        SS_n = 1'b1;
        wait_clk(10);
        n_checks++;
        if ((done_cnt - d0) != 0 || (err_cnt - e0) != 0) begin
            n_fail++;
            $display("FAIL reset_midframe pulses: done %0d err %0d expected 0/0",
                     done_cnt - d0, err_cnt - e0);
        end
        n_checks++;
        if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_midframe miso: got %b expected 0", MISO); end
        n_checks++;
        if (chnl !== 3'd0) begin n_fail++; $display("FAIL reset_midframe chnl: got %0d expected 0", chnl); end
        model_frame("after_reset", 3'd2);
    endtask

    task automatic test_random;
        for (int k = 0; k < 10; k++) begin
            for (int n = 0; n < 8; n++) ch_val[n] = 12'($urandom);
            model_frame("random", 3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        for (int n = 0; n < 8; n++) ch_val[n] = 12'($urandom);
        test_reset();
        test_first_frame();
        test_select_ch3();
        test_back_to_back();
        test_short_frame();
        test_midframe_change();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
